// File: rtl/regfile_pkg.sv
// Shared widths and types for the MIPS register file and its late-write scoreboard.
package regfile_pkg;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: tracks registers still owed a mul/div result,
// keeps a running count of them and flags issue/writeback protocol errors.
module reg_scoreboard
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  reg_addr_t       iss_addr,
  input  logic            lwe,
  input  reg_addr_t       lwa,
  output logic [NREG-1:0] busy,
  output logic [AW:0]     busy_cnt,
  output logic            err
);
  logic            iss_ok;
  logic            lw_ok;
  logic            same_addr;
  logic            inc;
  logic            dec;
  logic            err_set;
  logic [NREG-1:0] busy_nxt;

  assign iss_ok    = iss_valid && (iss_addr != ZERO_REG);
  assign lw_ok     = lwe && (lwa != ZERO_REG);
  assign same_addr = iss_ok && lw_ok && (iss_addr == lwa);

  // The issue is applied after the clear so a same-address issue keeps the bit set.
  always_comb begin
    busy_nxt = busy;
    if (lw_ok)
      busy_nxt[lwa] = 1'b0;
    if (iss_ok)
      busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign inc     = iss_ok && !busy[iss_addr];
  assign dec     = lw_ok && busy[lwa] && !same_addr;
  assign err_set = (iss_ok && busy[iss_addr] && !same_addr) ||
                   (lw_ok && !busy[lwa]);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
      err      <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
      if (err_set)
        err <= 1'b1;
    end
  end
endmodule

// File: rtl/regfile_wb.sv
// 32-entry register file with a primary WB write port, a late mul/div write port,
// two bypassed combinational read ports and a pending-write scoreboard.
module regfile_wb
  import regfile_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          lwe,
  input  logic [AW-1:0] lwa,
  input  logic [DW-1:0] lwd,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_addr,
  output logic          busy1,
  output logic          busy2,
  output logic [AW:0]   busy_cnt,
  output logic          err
);
  reg_data_t       regs [NREG];
  logic [NREG-1:0] busy;
  logic            pw_ok;
  logic            lw_ok;

  assign pw_ok = we && (wa != ZERO_REG);
  assign lw_ok = lwe && (lwa != ZERO_REG) && !(we && (wa == lwa));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else begin
      if (pw_ok)
        regs[wa] <= wd;
      if (lw_ok)
        regs[lwa] <= lwd;
    end
  end

  // Primary write beats late write beats stored value; register 0 is hardwired.
  function automatic reg_data_t read_port(input reg_addr_t ra);
    if (ra == ZERO_REG)
      return '0;
    else if (we && (wa == ra))
      return wd;
    else if (lwe && (lwa == ra))
      return lwd;
    else
      return regs[ra];
  endfunction

  assign rd1 = read_port(ra1);
  assign rd2 = read_port(ra2);

  assign busy1 = busy[ra1] && !(lwe && (lwa == ra1));
  assign busy2 = busy[ra2] && !(lwe && (lwa == ra2));

  reg_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .lwe       (lwe),
    .lwa       (lwa),
    .busy      (busy),
    .busy_cnt  (busy_cnt),
    .err       (err)
  );
endmodule
